// File: rtl/regfile_wb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_pkg
// Shared constants and types for the regfile writeback arbiter.
//   DATA_W / ADDR_W / NUM_REGS : register file geometry (32 x 32-bit)
//   wb_req_t                   : one pending register write {sel, data}
//   wb_src_e                   : which source owns the write port this cycle
// -----------------------------------------------------------------------------
package regfile_wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] sel;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LQ   = 2'd2,
        WB_LD   = 2'd3
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// wb_load_fifo
// In-order buffer for load returns that lost the write port to the ALU.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset (pointers/count only)
//   i_push        : write i_push_req at the tail (ignored when full)
//   i_push_req    : {sel, data} to enqueue
//   i_pop         : retire the head entry (ignored when empty)
//   o_head        : current head entry
//   o_count       : occupancy, 0..DEPTH
//   o_full/o_empty: occupancy flags
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module wb_load_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  wb_req_t                  i_push_req,
    input  logic                     i_pop,
    output wb_req_t                  o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    wb_req_t            r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == DEPTH_C);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage carries no reset; only the control state below does.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Writer side of the 32x32 register file. Merges in-order ALU writeback with
// out-of-order load returns onto the single registered write port.
// Priority each cycle: ALU > load-queue head > direct (bypassing) load.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   alu_wb_en/sel/data            : pipeline writeback, always accepted
//   ld_rsp_valid/ready/sel/data   : load return handshake
//   ld_issue_en/sel               : load issue, sets scoreboard bit
//   reg_busy                      : per-register load-pending vector
//   wb_stall_req                  : asks the pipeline to hold off ALU writes
//   lq_count                      : load queue occupancy
//   reg_wrt_sel/data/en           : regfile write port (registered)
// Build option: define REGFILE_WB_SCOREBOARD_EN to enable the reg_busy
// scoreboard; otherwise reg_busy is tied to zero and ld_issue_* is ignored.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int LQ_DEPTH     = 4,
    parameter int STARVE_MAX   = 8,
    parameter int R0_HARDWIRED = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_wb_en,
    input  logic [ADDR_W-1:0]         alu_wb_sel,
    input  logic [DATA_W-1:0]         alu_wb_data,
    input  logic                      ld_rsp_valid,
    output logic                      ld_rsp_ready,
    input  logic [ADDR_W-1:0]         ld_rsp_sel,
    input  logic [DATA_W-1:0]         ld_rsp_data,
    input  logic                      ld_issue_en,
    input  logic [ADDR_W-1:0]         ld_issue_sel,
    output logic [NUM_REGS-1:0]       reg_busy,
    output logic                      wb_stall_req,
    output logic [$clog2(LQ_DEPTH):0] lq_count,
    output logic [ADDR_W-1:0]         reg_wrt_sel,
    output logic [DATA_W-1:0]         reg_wrt_data,
    output logic                      reg_wrt_en
);

    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [STV_W-1:0] STV_MAX_C = STV_W'(STARVE_MAX);

    wb_src_e           w_src;
    wb_req_t           w_win_req;
    wb_req_t           w_head;
    wb_req_t           w_ld_req;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic [STV_W-1:0]  w_starve_nxt;

    logic [STV_W-1:0]  r_starve;
    logic              r_stall;
    logic [ADDR_W-1:0] r_wrt_sel;
    logic [DATA_W-1:0] r_wrt_data;
    logic              r_wrt_en;

    // Ready depends only on state (and reset), never on ld_rsp_valid.
    assign ld_rsp_ready = rst_n & ~w_full;
    assign w_accept     = ld_rsp_valid & ld_rsp_ready;
    assign w_ld_req     = '{sel: ld_rsp_sel, data: ld_rsp_data};

    wb_load_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_req (w_ld_req),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (lq_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Source selection. An accepted load that does not win the port is
    // queued; popping the head while queueing a new load keeps count steady.
    always_comb begin
        w_src     = WB_NONE;
        w_win_req = '0;
        w_pop     = 1'b0;
        if (alu_wb_en) begin
            w_src     = WB_ALU;
            w_win_req = '{sel: alu_wb_sel, data: alu_wb_data};
        end else if (!w_empty) begin
            w_src     = WB_LQ;
            w_win_req = w_head;
            w_pop     = 1'b1;
        end else if (w_accept) begin
            w_src     = WB_LD;
            w_win_req = w_ld_req;
        end
    end

    assign w_push = w_accept && (w_src != WB_LD);
    // Writes to r0 are consumed as normal but never reach the regfile.
    assign w_drop = (R0_HARDWIRED != 0) && (w_win_req.sel == '0);

    // Starvation: count ALU-won cycles while loads wait; any pop or an
    // empty queue restarts the count.
    always_comb begin
        w_starve_nxt = r_starve;
        if (w_empty || w_pop) begin
            w_starve_nxt = '0;
        end else if (alu_wb_en && (r_starve != STV_MAX_C)) begin
            w_starve_nxt = r_starve + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_starve <= w_starve_nxt;
            r_stall  <= (w_starve_nxt == STV_MAX_C);
        end
    end

    assign wb_stall_req = r_stall;

    // Registered write port: selection in cycle N reaches the regfile in N+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrt_en   <= 1'b0;
            r_wrt_sel  <= '0;
            r_wrt_data <= '0;
        end else begin
            r_wrt_en <= (w_src != WB_NONE) && !w_drop;
            if (w_src != WB_NONE) begin
                r_wrt_sel  <= w_win_req.sel;
                r_wrt_data <= w_win_req.data;
            end
        end
    end

    assign reg_wrt_en   = r_wrt_en;
    assign reg_wrt_sel  = r_wrt_sel;
    assign reg_wrt_data = r_wrt_data;

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_set;
    logic [NUM_REGS-1:0] w_busy_clr;

    // Clear on a load-sourced write leaving the arbiter (even a dropped r0
    // write); a same-cycle issue to that register wins over the clear.
    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (ld_issue_en && !((R0_HARDWIRED != 0) && (ld_issue_sel == '0))) begin
            w_busy_set[ld_issue_sel] = 1'b1;
        end
        if ((w_src == WB_LQ) || (w_src == WB_LD)) begin
            w_busy_clr[w_win_req.sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_busy_clr) | w_busy_set;
        end
    end

    assign reg_busy = r_busy;
`else
    logic w_unused_issue;
    assign w_unused_issue = ^{ld_issue_en, ld_issue_sel};
    assign reg_busy       = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    import regfile_wb_pkg::*;

    logic                clk;
    logic                rst_n;
    logic                alu_wb_en;
    logic [ADDR_W-1:0]   alu_wb_sel;
    logic [DATA_W-1:0]   alu_wb_data;
    logic                ld_rsp_valid;
    logic                ld_rsp_ready;
    logic [ADDR_W-1:0]   ld_rsp_sel;
    logic [DATA_W-1:0]   ld_rsp_data;
    logic                ld_issue_en;
    logic [ADDR_W-1:0]   ld_issue_sel;
    logic [NUM_REGS-1:0] reg_busy;
    logic                wb_stall_req;
    logic [2:0]          lq_count;
    logic [ADDR_W-1:0]   reg_wrt_sel;
    logic [DATA_W-1:0]   reg_wrt_data;
    logic                reg_wrt_en;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter #(
        .LQ_DEPTH     (4),
        .STARVE_MAX   (8),
        .R0_HARDWIRED (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_wb_en    (alu_wb_en),
        .alu_wb_sel   (alu_wb_sel),
        .alu_wb_data  (alu_wb_data),
        .ld_rsp_valid (ld_rsp_valid),
        .ld_rsp_ready (ld_rsp_ready),
        .ld_rsp_sel   (ld_rsp_sel),
        .ld_rsp_data  (ld_rsp_data),
        .ld_issue_en  (ld_issue_en),
        .ld_issue_sel (ld_issue_sel),
        .reg_busy     (reg_busy),
        .wb_stall_req (wb_stall_req),
        .lq_count     (lq_count),
        .reg_wrt_sel  (reg_wrt_sel),
        .reg_wrt_data (reg_wrt_data),
        .reg_wrt_en   (reg_wrt_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [ADDR_W-1:0] sel,
                          input logic [DATA_W-1:0] data);
        chk({tag, "_en"}, 64'(reg_wrt_en), 64'(en));
        if (en) begin
            chk({tag, "_sel"}, 64'(reg_wrt_sel), 64'(sel));
            chk({tag, "_data"}, 64'(reg_wrt_data), 64'(data));
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        alu_wb_en    = 1'b0;
        alu_wb_sel   = '0;
        alu_wb_data  = '0;
        ld_rsp_valid = 1'b1;
        ld_rsp_sel   = 5'd5;
        ld_rsp_data  = 32'h1234;
        ld_issue_en  = 1'b0;
        ld_issue_sel = '0;

        // Reset held with a pending load
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", 64'(ld_rsp_ready), 64'd0);
            chk("rst_wrt_en", 64'(reg_wrt_en), 64'd0);
            chk("rst_count", 64'(lq_count), 64'd0);
        end
        chk("rst_stall", 64'(wb_stall_req), 64'd0);
        chk("rst_busy", 64'(reg_busy), 64'd0);
        ld_rsp_valid = 1'b0;
        rst_n        = 1'b1;
        #1;
        chk("post_rst_ready", 64'(ld_rsp_ready), 64'd1);
        tick();
        chk("idle_wrt_en", 64'(reg_wrt_en), 64'd0);

        // Direct load bypasses the queue
        ld_rsp_valid = 1'b1;
        ld_rsp_sel   = 5'd5;
        ld_rsp_data  = 32'hDEAD_BEEF;
        tick();
        ld_rsp_valid = 1'b0;
        chk_wr("direct", 1'b1, 5'd5, 32'hDEAD_BEEF);
        chk("direct_count", 64'(lq_count), 64'd0);
        tick();
        chk("direct_after_en", 64'(reg_wrt_en), 64'd0);

        // Collision: ALU first, queued load next cycle
        alu_wb_en    = 1'b1;
        alu_wb_sel   = 5'd3;
        alu_wb_data  = 32'd1;
        ld_rsp_valid = 1'b1;
        ld_rsp_sel   = 5'd7;
        ld_rsp_data  = 32'd2;
        tick();
        alu_wb_en    = 1'b0;
        ld_rsp_valid = 1'b0;
        chk_wr("coll_alu", 1'b1, 5'd3, 32'd1);
        chk("coll_count1", 64'(lq_count), 64'd1);
        tick();
        chk_wr("coll_ld", 1'b1, 5'd7, 32'd2);
        chk("coll_count0", 64'(lq_count), 64'd0);
        tick();
        chk("coll_idle", 64'(reg_wrt_en), 64'd0);

        // Writes to r0 are dropped
        alu_wb_en   = 1'b1;
        alu_wb_sel  = 5'd0;
        alu_wb_data = 32'h55;
        tick();
        alu_wb_en = 1'b0;
        chk("r0_alu_en", 64'(reg_wrt_en), 64'd0);
        ld_rsp_valid = 1'b1;
        ld_rsp_sel   = 5'd0;
        ld_rsp_data  = 32'h77;
        #1;
        chk("r0_ld_ready", 64'(ld_rsp_ready), 64'd1);
        tick();
        ld_rsp_valid = 1'b0;
        chk("r0_ld_en", 64'(reg_wrt_en), 64'd0);
        chk("r0_ld_count", 64'(lq_count), 64'd0);

        // Fill under continuous ALU writes, then starvation stall and drain
        alu_wb_en   = 1'b1;
        alu_wb_sel  = 5'd1;
        alu_wb_data = 32'd100;
        for (int i = 0; i < 4; i++) begin
            ld_rsp_valid = 1'b1;
            ld_rsp_sel   = 5'(10 + i);
            ld_rsp_data  = 32'hA0 + 32'(i);
            tick();
            chk("fill_count", 64'(lq_count), 64'(i + 1));
        end
        chk_wr("fill_alu", 1'b1, 5'd1, 32'd100);
        ld_rsp_sel  = 5'd14;
        ld_rsp_data = 32'hA4;
        chk("full_ready", 64'(ld_rsp_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("full_hold_count", 64'(lq_count), 64'd4);
            chk("full_hold_ready", 64'(ld_rsp_ready), 64'd0);
            chk("stall_low", 64'(wb_stall_req), 64'd0);
        end
        tick();
        chk("stall_high", 64'(wb_stall_req), 64'd1);
        alu_wb_en = 1'b0;
        tick();
        chk_wr("drain0", 1'b1, 5'd10, 32'hA0);
        chk("drain0_count", 64'(lq_count), 64'd3);
        chk("drain0_stall", 64'(wb_stall_req), 64'd0);
        chk("drain0_ready", 64'(ld_rsp_ready), 64'd1);
        tick();
        ld_rsp_valid = 1'b0;
        chk_wr("drain1", 1'b1, 5'd11, 32'hA1);
        chk("drain1_count", 64'(lq_count), 64'd3);
        for (int i = 2; i < 5; i++) begin
            tick();
            chk_wr("drain_n", 1'b1, 5'(10 + i), 32'hA0 + 32'(i));
            chk("drain_n_count", 64'(lq_count), 64'(4 - i));
        end
        tick();
        chk("drain_done_en", 64'(reg_wrt_en), 64'd0);

        // Mid-operation reset discards queued loads
        alu_wb_en    = 1'b1;
        alu_wb_sel   = 5'd2;
        ld_rsp_valid = 1'b1;
        ld_rsp_sel   = 5'd20;
        tick();
        tick();
        chk("pre_rst_count", 64'(lq_count), 64'd2);
        alu_wb_en    = 1'b0;
        ld_rsp_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        chk("mid_rst_count", 64'(lq_count), 64'd0);
        chk("mid_rst_ready", 64'(ld_rsp_ready), 64'd0);
        chk("mid_rst_en", 64'(reg_wrt_en), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_mid_rst_en", 64'(reg_wrt_en), 64'd0);
        chk("post_mid_rst_count", 64'(lq_count), 64'd0);

`ifdef REGFILE_WB_SCOREBOARD_EN
        ld_issue_en  = 1'b1;
        ld_issue_sel = 5'd9;
        tick();
        ld_issue_en = 1'b0;
        chk("sb_set", 64'(reg_busy[9]), 64'd1);
        ld_rsp_valid = 1'b1;
        ld_rsp_sel   = 5'd9;
        ld_rsp_data  = 32'h99;
        tick();
        ld_rsp_valid = 1'b0;
        chk_wr("sb_ret", 1'b1, 5'd9, 32'h99);
        chk("sb_clr", 64'(reg_busy[9]), 64'd0);
        ld_issue_en  = 1'b1;
        ld_issue_sel = 5'd9;
        ld_rsp_valid = 1'b1;
        tick();
        ld_issue_en  = 1'b0;
        ld_rsp_valid = 1'b0;
        chk("sb_set_wins", 64'(reg_busy[9]), 64'd1);
        ld_issue_en  = 1'b1;
        ld_issue_sel = 5'd0;
        tick();
        ld_issue_en = 1'b0;
        chk("sb_r0", 64'(reg_busy[0]), 64'd0);
`else
        ld_issue_en  = 1'b1;
        ld_issue_sel = 5'd9;
        tick();
        ld_rsp_valid = 1'b1;
        ld_rsp_sel   = 5'd9;
        tick();
        ld_issue_en  = 1'b0;
        ld_rsp_valid = 1'b0;
        chk("nosb_busy", 64'(reg_busy), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
